// File: rtl/rotation_aligner.sv
// ---------------------------------------------------------------------------
// rotation_aligner
//
// Receive-side partner of the rotating barrel shifter. The transmitter rotates
// every word left by an unknown but constant amount k. This block finds k by
// searching for the frame sync word, confirms it over several frames, locks,
// and then rotates each word right by k to restore the original data.
//
// Optional feature (macro ALIGN_STATS_EN): adds the relock_cnt and miss_total
// statistics outputs. With the macro undefined, those ports and their
// counters are absent.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data is valid this cycle (no backpressure)
//   in_data    in   rotated input word
//   out_valid  out  out_data is valid
//   out_data   out  de-rotated word
//   out_sop    out  qualifies out_valid: word sits in the sync slot
//   sync_err   out  qualifies out_valid: sync slot held the wrong pattern
//   locked     out  high while aligned
//   rot_amt    out  current candidate or locked rotation
//   relock_cnt out  (ALIGN_STATS_EN) saturating count of lock losses
//   miss_total out  (ALIGN_STATS_EN) saturating count of sync_err words
// ---------------------------------------------------------------------------
module rotation_aligner #(
   parameter int         WIDTH        = 8,
   parameter logic [7:0] SYNC_PATTERN = 8'hE4,
   parameter int         FRAME_LEN    = 16,
   parameter int         LOCK_COUNT   = 3,
   parameter int         LOSS_COUNT   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sop,
   output logic             sync_err,
   output logic             locked,
   output logic [2:0]       rot_amt
`ifdef ALIGN_STATS_EN
   ,
   output logic [7:0]       relock_cnt,
   output logic [15:0]      miss_total
`endif
);

   localparam int POS_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_LEN - 1);
   localparam logic [3:0]       GOOD_LAST = 4'(LOCK_COUNT - 1);
   localparam logic [3:0]       MISS_LAST = 4'(LOSS_COUNT - 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [3:0]       good_q, good_d;
   logic [3:0]       miss_q, miss_d;
   logic [2:0]       rot_q, rot_d;
   logic             outValid_q, outValid_d;
   logic [WIDTH-1:0] outData_q, outData_d;
   logic             outSop_q, outSop_d;
   logic             syncErr_q, syncErr_d;

   logic             matchHit;
   logic [2:0]       matchAmt;
   logic [WIDTH-1:0] curRot;
   logic             curMatch;
   logic             atSync;
   logic [POS_W-1:0] posNext;
   logic             lockedMiss;
   logic             lossEvent;

   function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                             input logic [2:0]       r);
      logic [2*WIDTH-1:0] t;
      t = {x, x} >> r;
      return t[WIDTH-1:0];
   endfunction

   // Try all eight right-rotations at once; the sync word's rotations are all
   // distinct, so at most one can hit.
   always_comb begin
      matchHit = 1'b0;
      matchAmt = 3'd0;
      for (int r = 0; r < 8; r++) begin
         if (rotr(in_data, 3'(r)) == SYNC_PATTERN) begin
            matchHit = 1'b1;
            matchAmt = 3'(r);
         end
      end
   end

   // Shared decode of the incoming word against the current rotation.
   always_comb begin
      curRot     = rotr(in_data, rot_q);
      curMatch   = (curRot == SYNC_PATTERN);
      atSync     = (pos_q == '0);
      posNext    = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
      lockedMiss = in_valid && (state_q == LOCKED) && atSync && !curMatch;
      lossEvent  = lockedMiss && (miss_q == MISS_LAST);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: only valid words can move the FSM.
   always_comb begin
      state_d = state_q;
      if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (matchHit) begin
                  state_d = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
               end
            end
            VERIFY: begin
               if (atSync) begin
                  if (curMatch) begin
                     if (good_q == GOOD_LAST) begin
                        state_d = LOCKED;
                     end
                  end else if (!matchHit) begin
                     state_d = HUNT;
                  end
               end
            end
            LOCKED: begin
               if (lossEvent) begin
                  state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // Datapath next values: frame position, lock/miss counters, candidate
   // rotation and the registered output word.
   always_comb begin
      pos_d      = pos_q;
      good_d     = good_q;
      miss_d     = miss_q;
      rot_d      = rot_q;
      outValid_d = 1'b0;
      outData_d  = outData_q;
      outSop_d   = outSop_q;
      syncErr_d  = syncErr_q;
      if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (matchHit) begin
                  rot_d  = matchAmt;
                  pos_d  = POS_W'(1);
                  good_d = 4'd1;
               end
            end
            VERIFY: begin
               pos_d = posNext;
               if (atSync) begin
                  if (curMatch) begin
                     good_d = good_q + 4'd1;
                  end else if (matchHit) begin
                     rot_d  = matchAmt;
                     good_d = 4'd1;
                  end else begin
                     pos_d  = '0;
                     good_d = 4'd0;
                  end
               end
            end
            LOCKED: begin
               outValid_d = 1'b1;
               outData_d  = curRot;
               outSop_d   = atSync;
               syncErr_d  = atSync && !curMatch;
               pos_d      = posNext;
               if (atSync) begin
                  if (curMatch) begin
                     miss_d = 4'd0;
                  end else if (lossEvent) begin
                     miss_d = 4'd0;
                     pos_d  = '0;
                  end else begin
                     miss_d = miss_q + 4'd1;
                  end
               end
            end
            default: begin
               pos_d = '0;
            end
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q      <= '0;
         good_q     <= 4'd0;
         miss_q     <= 4'd0;
         rot_q      <= 3'd0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outSop_q   <= 1'b0;
         syncErr_q  <= 1'b0;
      end else begin
         pos_q      <= pos_d;
         good_q     <= good_d;
         miss_q     <= miss_d;
         rot_q      <= rot_d;
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outSop_q   <= outSop_d;
         syncErr_q  <= syncErr_d;
      end
   end

`ifdef ALIGN_STATS_EN
   logic [7:0]  relock_q, relock_d;
   logic [15:0] missTotal_q, missTotal_d;

   // Saturating statistics counters.
   always_comb begin
      relock_d    = relock_q;
      missTotal_d = missTotal_q;
      if (lossEvent && (relock_q != 8'hFF)) begin
         relock_d = relock_q + 8'd1;
      end
      if (lockedMiss && (missTotal_q != 16'hFFFF)) begin
         missTotal_d = missTotal_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         relock_q    <= 8'd0;
         missTotal_q <= 16'd0;
      end else begin
         relock_q    <= relock_d;
         missTotal_q <= missTotal_d;
      end
   end

   assign relock_cnt = relock_q;
   assign miss_total = missTotal_q;
`endif

   // Output logic: lock flag decoded from state, everything else registered.
   always_comb begin
      locked    = (state_q == LOCKED);
      rot_amt   = rot_q;
      out_valid = outValid_q;
      out_data  = outData_q;
      out_sop   = outSop_q;
      sync_err  = syncErr_q;
   end

endmodule
